traceback_ctrl: RTL and testbench

Traceback sequencer for the Needleman-Wunsch alignment datapath, sitting directly downstream of the direction RAM. After the fill phase completes, it walks the stored arrow matrix from cell (len_a, len_b) back to (0,0), driving the RAM's traceback read port. It emits one alignment move per visited cell on a valid/ready stream to the alignment-string builder. It reports completion, path length and malformed-matrix errors.

---
 rtl/traceback_if.sv | 33 +++
 rtl/traceback_ctrl.sv | 166 ++++++++++++++++
 tb/tb_traceback_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traceback_if.sv
// traceback_if: stream/control bundle between the Needleman-Wunsch traceback
// sequencer, the direction RAM read port and the alignment-string builder.
// master = sequencer side, slave = environment side (RAM + consumer + host).
interface traceback_if #(
    parameter int N = 128
);
    localparam int BitAddr = $clog2(N + 1);

    logic                 start;
    logic [BitAddr:0]     len_a;
    logic [BitAddr:0]     len_b;
    logic [2:0]           symbol_in;
    logic                 en_traceB;
    logic [BitAddr:0]     i_t;
    logic [BitAddr:0]     j_t;
    logic [2:0]           move_out;
    logic                 move_valid;
    logic                 move_ready;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [BitAddr+1:0]   path_len;

    modport master (
        input  start, len_a, len_b, symbol_in, move_ready,
        output en_traceB, i_t, j_t, move_out, move_valid, busy, done, err, path_len
    );

    modport slave (
        output start, len_a, len_b, symbol_in, move_ready,
        input  en_traceB, i_t, j_t, move_out, move_valid, busy, done, err, path_len
    );
endinterface

// File: rtl/traceback_ctrl.sv
// traceback_ctrl: walks the Needleman-Wunsch arrow matrix from (len_a,len_b)
// back to (0,0), one RAM read per cell, emitting one move per cell on a
// valid/ready stream.
// Optional feature macro: TRACEBACK_BOUND_CHECK_EN
//   defined   -> malformed symbols / out-of-range moves raise err and stop
//   undefined -> symbols decoded by priority, moves clamped at the borders
module traceback_ctrl #(
    parameter int N = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    traceback_if.master  tb_if
);
    localparam int BitAddr = $clog2(N + 1);
    localparam int AW      = BitAddr + 1;
    localparam int PW      = BitAddr + 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [2:0] MV_DIAG = 3'b001;
    localparam logic [2:0] MV_UP   = 3'b010;
    localparam logic [2:0] MV_LEFT = 3'b100;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;
    logic [2:0]    move_q, move_d;
    logic [PW-1:0] plen_q, plen_d;
    logic          err_q, err_d;

    logic [AW-1:0] len_a_clamp;
    logic [AW-1:0] len_b_clamp;
    logic [2:0]    dec_move;
    logic          dec_err;
    logic          step_i;
    logic          step_j;
    logic [AW-1:0] i_next;
    logic [AW-1:0] j_next;

    // Lengths beyond the matrix size are clamped so the walk never leaves the RAM.
    assign len_a_clamp = (tb_if.len_a > AW'(N)) ? AW'(N) : tb_if.len_a;
    assign len_b_clamp = (tb_if.len_b > AW'(N)) ? AW'(N) : tb_if.len_b;

    // Column moves on DIAG/LEFT, row moves on DIAG/UP; never step below zero.
    assign step_i = (move_q[0] | move_q[2]) & (i_q != '0);
    assign step_j = (move_q[0] | move_q[1]) & (j_q != '0);
    assign i_next = i_q - {{(AW-1){1'b0}}, step_i};
    assign j_next = j_q - {{(AW-1){1'b0}}, step_j};

    // Decode the RAM symbol for the current cell into a legal move (or an error).
    always_comb begin
        dec_move = MV_DIAG;
        dec_err  = 1'b0;
`ifdef TRACEBACK_BOUND_CHECK_EN
        dec_move = tb_if.symbol_in;
        if (!(tb_if.symbol_in == MV_DIAG || tb_if.symbol_in == MV_UP ||
              tb_if.symbol_in == MV_LEFT)) begin
            dec_err = 1'b1;
        end else if ((tb_if.symbol_in[0] | tb_if.symbol_in[2]) && (i_q == '0)) begin
            dec_err = 1'b1;
        end else if ((tb_if.symbol_in[0] | tb_if.symbol_in[1]) && (j_q == '0)) begin
            dec_err = 1'b1;
        end
`else
        if (i_q == '0) begin
            dec_move = MV_UP;
        end else if (j_q == '0) begin
            dec_move = MV_LEFT;
        end else if (tb_if.symbol_in[0] || (tb_if.symbol_in == 3'b000)) begin
            dec_move = MV_DIAG;
        end else if (tb_if.symbol_in[1]) begin
            dec_move = MV_UP;
        end else begin
            dec_move = MV_LEFT;
        end
`endif
    end

    // Sequencer next-state: IDLE -> READ -> WAIT -> EMIT -> (READ | FIN) -> IDLE.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        move_d  = move_q;
        plen_d  = plen_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (tb_if.start) begin
                    i_d    = len_a_clamp;
                    j_d    = len_b_clamp;
                    plen_d = '0;
                    err_d  = 1'b0;
                    if (len_a_clamp == '0 && len_b_clamp == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dec_err) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    move_d  = dec_move;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (tb_if.move_ready) begin
                    plen_d = plen_q + PW'(1);
                    i_d    = i_next;
                    j_d    = j_next;
                    if (i_next == '0 && j_next == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run immediately without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            move_q  <= '0;
            plen_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            move_q  <= move_d;
            plen_q  <= plen_d;
            err_q   <= err_d;
        end
    end

    assign tb_if.en_traceB  = (state_q == S_READ);
    assign tb_if.move_valid = (state_q == S_EMIT);
    assign tb_if.busy       = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_EMIT);
    assign tb_if.done       = (state_q == S_FIN);
    assign tb_if.i_t        = i_q;
    assign tb_if.j_t        = j_q;
    assign tb_if.move_out   = move_q;
    assign tb_if.path_len   = plen_q;
    assign tb_if.err        = err_q;
endmodule

// File: tb/tb_traceback_ctrl.sv
// tb_traceback_ctrl: scoreboard bench for traceback_ctrl with N=4 and a
// behavioural direction RAM. Stimulus pushes expected (move,i,j) tuples;
// a monitor pops and compares on every move handshake.
module tb_traceback_ctrl;
    localparam int N  = 4;
    localparam int NP = N + 1;

    localparam logic [2:0] DIAG = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] LEFT = 3'b100;

    typedef struct packed {
        logic [2:0] mv;
        logic [3:0] i;
        logic [3:0] j;
    } exp_t;

    logic clk;
    logic rst_n;
    traceback_if #(.N(N)) bus ();

    traceback_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tb_if (bus)
    );

    logic [2:0] mem [0:NP*NP-1];
    exp_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         en_cnt   = 0;
    int         done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural direction RAM: registered read on en_traceB.
    always @(posedge clk) begin
        if (bus.en_traceB) bus.symbol_in <= mem[int'(bus.i_t) + NP * int'(bus.j_t)];
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    // Monitor: compare every handshake against the scoreboard, tally strobes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.en_traceB) en_cnt++;
                if (bus.done) done_cnt++;
                if (bus.en_traceB && bus.move_valid) chk("read_while_emit", 1, 0);
                if (bus.move_valid && bus.move_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_move", int'(bus.move_out), 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("move_out", int'(bus.move_out), int'(e.mv));
                        chk("move_i", int'(bus.i_t), int'(e.i));
                        chk("move_j", int'(bus.j_t), int'(e.j));
                        $display("move mv=%b i=%0d j=%0d path_len=%0d", bus.move_out, bus.i_t, bus.j_t, bus.path_len);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] mv, input int i, input int j);
        exp_t e;
        e.mv = mv;
        e.i  = 4'(i);
        e.j  = 4'(j);
        sb_q.push_back(e);
    endtask

    task automatic fill(input logic [2:0] v);
        for (int k = 0; k < NP * NP; k++) mem[k] = v;
    endtask

    // Pulse start for one edge; returns positioned in the cycle after acceptance.
    task automatic do_start(input int la, input int lb);
        bus.len_a = 4'(la);
        bus.len_b = 4'(lb);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Wait for done with a budget; cyc counts cycles since the accepting edge.
    task automatic wait_done(inout int cyc, input string name);
        int budget;
        budget = 200;
        while (!bus.done && budget > 0) begin
            step();
            cyc++;
            budget--;
        end
        if (!bus.done) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string name);
        int budget;
        budget = 50;
        while (!bus.move_valid && budget > 0) begin
            step();
            budget--;
        end
        if (!bus.move_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int cyc;
        int d0;
        int e0;
        bus.start      = 1'b0;
        bus.len_a      = '0;
        bus.len_b      = '0;
        bus.move_ready = 1'b1;
        bus.symbol_in  = '0;
        rst_n          = 1'b0;
        fill(DIAG);
        repeat (3) step();

        // Reset state
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_valid", int'(bus.move_valid), 0);
        chk("rst_path_len", int'(bus.path_len), 0);
        rst_n = 1'b1;
        step();

        // Test 1: 3x3 all-DIAG, done at cycle 10, start while busy ignored
        push(DIAG, 3, 3);
        push(DIAG, 2, 2);
        push(DIAG, 1, 1);
        d0 = done_cnt;
        e0 = en_cnt;
        do_start(3, 3);
        cyc = 1;
        step(); cyc++;
        chk("t1_busy", int'(bus.busy), 1);
        do_start(1, 1); cyc++;
        wait_done(cyc, "t1_done");
        chk("t1_done_cycle", cyc, 10);
        chk("t1_path_len", int'(bus.path_len), 3);
        chk("t1_err", int'(bus.err), 0);
        chk("t1_busy_fin", int'(bus.busy), 0);
        step();
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_reads", en_cnt - e0, 3);
        chk("t1_sb_empty", sb_q.size(), 0);
        $display("test1 path_len=%0d cycles=%0d", bus.path_len, cyc);

        // Test 2: 2x3 path LEFT,DIAG,UP,UP
        fill(3'b000);
        mem[2 + NP * 3] = LEFT;
        mem[1 + NP * 3] = DIAG;
        mem[0 + NP * 2] = UP;
        mem[0 + NP * 1] = UP;
        push(LEFT, 2, 3);
        push(DIAG, 1, 3);
        push(UP, 0, 2);
        push(UP, 0, 1);
        d0 = done_cnt;
        do_start(2, 3);
        cyc = 1;
        wait_done(cyc, "t2_done");
        chk("t2_path_len", int'(bus.path_len), 4);
        chk("t2_i_end", int'(bus.i_t), 0);
        chk("t2_j_end", int'(bus.j_t), 0);
        step();
        chk("t2_done_pulses", done_cnt - d0, 1);
        chk("t2_sb_empty", sb_q.size(), 0);
        $display("test2 path_len=%0d", bus.path_len);

        // Test 3: stall 5 cycles in first EMIT
        push(LEFT, 2, 3);
        push(DIAG, 1, 3);
        push(UP, 0, 2);
        push(UP, 0, 1);
        bus.move_ready = 1'b0;
        do_start(2, 3);
        wait_valid("t3_valid");
        e0 = en_cnt;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_stall_valid", int'(bus.move_valid), 1);
            chk("t3_stall_move", int'(bus.move_out), int'(LEFT));
            chk("t3_stall_i", int'(bus.i_t), 2);
            chk("t3_stall_j", int'(bus.j_t), 3);
        end
        chk("t3_stall_reads", en_cnt - e0, 0);
        bus.move_ready = 1'b1;
        cyc = 0;
        wait_done(cyc, "t3_done");
        chk("t3_path_len", int'(bus.path_len), 4);
        step();
        chk("t3_sb_empty", sb_q.size(), 0);
        $display("test3 path_len=%0d", bus.path_len);

        // Test 4: zero-length run
        e0 = en_cnt;
        d0 = done_cnt;
        do_start(0, 0);
        chk("t4_done_next", int'(bus.done), 1);
        chk("t4_path_len", int'(bus.path_len), 0);
        chk("t4_busy", int'(bus.busy), 0);
        step();
        chk("t4_done_pulses", done_cnt - d0, 1);
        chk("t4_reads", en_cnt - e0, 0);
        $display("test4 path_len=%0d", bus.path_len);

        // Test 5: malformed symbol 3'b110 at (2,2)
        fill(DIAG);
        mem[2 + NP * 2] = 3'b110;
        mem[1]          = LEFT;
`ifdef TRACEBACK_BOUND_CHECK_EN
        do_start(2, 2);
        cyc = 1;
        wait_done(cyc, "t5_done");
        chk("t5_err", int'(bus.err), 1);
        chk("t5_path_len", int'(bus.path_len), 0);
`else
        push(UP, 2, 2);
        push(DIAG, 2, 1);
        push(LEFT, 1, 0);
        do_start(2, 2);
        cyc = 1;
        wait_done(cyc, "t5_done");
        chk("t5_err", int'(bus.err), 0);
        chk("t5_path_len", int'(bus.path_len), 3);
`endif
        step();
        chk("t5_sb_empty", sb_q.size(), 0);
        $display("test5 err=%0d path_len=%0d", bus.err, bus.path_len);

        // Test 6: asynchronous reset during EMIT, then fresh run
        fill(3'b000);
        mem[2 + NP * 3] = LEFT;
        push(LEFT, 2, 3);
        bus.move_ready = 1'b0;
        do_start(2, 3);
        wait_valid("t6_valid");
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en", int'(bus.en_traceB), 0);
        chk("t6_rst_i", int'(bus.i_t), 0);
        chk("t6_rst_j", int'(bus.j_t), 0);
        chk("t6_rst_move", int'(bus.move_out), 0);
        chk("t6_rst_valid", int'(bus.move_valid), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_done", int'(bus.done), 0);
        chk("t6_rst_err", int'(bus.err), 0);
        chk("t6_rst_path_len", int'(bus.path_len), 0);
        sb_q.delete();
        bus.move_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t6_no_done", done_cnt - d0, 0);
        fill(DIAG);
        push(DIAG, 2, 2);
        push(DIAG, 1, 1);
        do_start(2, 2);
        cyc = 1;
        wait_done(cyc, "t6_done");
        chk("t6_done_cycle", cyc, 7);
        chk("t6_path_len", int'(bus.path_len), 2);
        step();
        chk("t6_sb_empty", sb_q.size(), 0);
        $display("test6 path_len=%0d", bus.path_len);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
